fxp_mul_seq: RTL and testbench
==============================

FXP_MUL_SEQ -- requirements
Module: fxp_mul_seq

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning operand/result width; only 32 is supported.
REQ-002 The block SHALL have parameter FRAC, default 16, meaning fraction bits (Q16.16); only 16 is supported.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  operand pair offered.
REQ-006 The block SHALL have port in_ready  output  1  block accepts operands.
REQ-007 The block SHALL have ports A and B, each input, 32 bits, signed Q16.16 operands ({int16, frac16}).
REQ-008 The block SHALL have port out_valid  output  1  result available.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 The block SHALL have port result  output  32  signed Q16.16 product.
REQ-011 The block SHALL have port ovf  output  1  product exceeded the Q16.16 range.

Function
REQ-012 The block SHALL time-share one 16x16 unsigned multiplier, using one partial product per cycle.
REQ-013 The FSM states SHALL be IDLE, LL, LH, HL, HH, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in every other state, in_ready SHALL be 0.
REQ-015 When in_valid and in_ready are both 1, the block SHALL do the following.
- Latch |A| and |B| as 32-bit unsigned magnitudes (|0x80000000| = 2^31).
- Latch neg = A[31] xor B[31].
- Clear the 64-bit accumulator.
- Go to LL.
REQ-016 The states LL, LH, HL and HH SHALL each take one cycle and add lo*lo, (lo*hi)<<16, (hi*lo)<<16 and (hi*hi)<<32 to the accumulator, in that order, then advance.
REQ-017 After HH, the block SHALL do the following.
- Form mag = acc[47:16] (truncation of magnitude, so rounding is toward zero).
- Set ovf if acc[63:48] != 0, or if mag exceeds 0x7FFFFFFF (positive) or 0x80000000 (negative).
- Drive result = neg ? -mag : mag (as modified by REQ-023).
- Enter DONE with out_valid = 1.
REQ-018 Latency SHALL be 5 cycles from the accept edge to the first out_valid = 1 cycle.
REQ-019 In DONE, result and ovf SHALL be held stable while out_ready = 0; when out_ready = 1, the block SHALL return to IDLE on the next edge with out_valid = 0.
REQ-020 A new operand SHALL NOT be accepted in the same cycle a result is consumed; at most one operation is in flight.
REQ-021 A zero operand SHALL yield result 0 with ovf 0, and a negative zero (-0) result SHALL NOT be produced.

Reset
REQ-022 When rst = 1 at an edge, in any state including mid-operation, the block SHALL do the following.
- Enter IDLE.
- Drive in_ready = 1, out_valid = 0, result = 0, ovf = 0.
- Clear the accumulator.
- Discard any partial operation.

Configuration
REQ-023 Saturation SHALL be controlled by macro FXP_MUL_SAT_EN.
- Defined: on overflow, result SHALL saturate to 0x7FFFFFFF (neg = 0) or 0x80000000 (neg = 1).
- Undefined: result SHALL be the low 32 bits of the signed product (wrap).
- In both cases, ovf SHALL be reported identically.

Structure
REQ-024 Package fxp_mul_pkg SHALL hold the following.
- The state enum.
- W and FRAC.
- Constants QMAX = 0x7FFFFFFF and QMIN = 0x80000000.
REQ-025 The block SHALL contain one combinational sub-module, mul16u (16x16 to 32 unsigned), instantiated once.

Verification
REQ-026 Accept A=0x00018000 (1.5), B=0x00034000 (3.25) -> after 5 cycles, result=0x0004E000, ovf=0.
REQ-027 Accept A=0xFFFE8000 (-1.5), B=0x00034000 -> result=0xFFFB2000, ovf=0.
REQ-028 Accept A=B=0x01000000 (256) -> ovf=1; result=0x7FFFFFFF with FXP_MUL_SAT_EN, 0x00000000 without.
REQ-029 Accept A=0x80000000, B=0x00010000 -> result=0x80000000, ovf=0; accept A=B=0x00000001 -> result=0x00000000.
REQ-030 Bench: hold out_ready=0 for 3 cycles in DONE -> result/ovf stable, in_ready=0; raise out_ready -> in_ready=1 on the next cycle.
REQ-031 Bench: assert rst in state LH -> next cycle in_ready=1, out_valid=0; a following 1.5*3.25 operation still yields 0x0004E000.

Source files
------------

// File: rtl/fxp_mul_pkg.sv
// Shared types and constants for the sequential Q16.16 multiplier.
package fxp_mul_pkg;

    localparam int W    = 32;
    localparam int FRAC = 16;

    localparam logic [31:0] QMAX = 32'h7FFF_FFFF;
    localparam logic [31:0] QMIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        LL,
        LH,
        HL,
        HH,
        DONE
    } state_t;

    // Two's-complement magnitude; 0x80000000 maps to 2^31 as an unsigned value.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/mul16u.sv
// Combinational 16x16 -> 32 unsigned multiplier shared across partial products.
module mul16u (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_p
);

    assign o_p = i_a * i_b;

endmodule

// File: rtl/fxp_mul_seq.sv
// Sequential signed Q16.16 multiplier: one 16x16 partial product per cycle.
// Optional saturation on overflow is enabled with `define FXP_MUL_SAT_EN.
module fxp_mul_seq #(
    parameter int W    = fxp_mul_pkg::W,
    parameter int FRAC = fxp_mul_pkg::FRAC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ovf
);

    import fxp_mul_pkg::*;

    localparam int H = W / 2;

    state_t              r_state;
    logic [W-1:0]        r_mag_a;
    logic [W-1:0]        r_mag_b;
    logic                r_neg;
    logic [2*W-1:0]      r_acc;
    logic [W-1:0]        r_result;
    logic                r_ovf;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [H-1:0]        w_op_a;
    logic [H-1:0]        w_op_b;
    logic [W-1:0]        w_pp;
    logic [2*W-1:0]      w_term;
    logic [2*W-1:0]      w_acc_fin;
    logic [W-1:0]        w_mag;
    logic                w_ovf;
    logic signed [W-1:0] w_signed;
    logic [W-1:0]        w_res;

    // Operand halves feeding the shared multiplier, chosen by the current phase.
    always_comb begin
        w_op_a = r_mag_a[H-1:0];
        w_op_b = r_mag_b[H-1:0];
        case (r_state)
            LH: w_op_b = r_mag_b[W-1:H];
            HL: w_op_a = r_mag_a[W-1:H];
            HH: begin
                w_op_a = r_mag_a[W-1:H];
                w_op_b = r_mag_b[W-1:H];
            end
            default: ;
        endcase
    end

    mul16u u_mul (
        .i_a (w_op_a),
        .i_b (w_op_b),
        .o_p (w_pp)
    );

    always_comb begin
        w_term = {{W{1'b0}}, w_pp};
        case (r_state)
            LH, HL:  w_term = {{H{1'b0}}, w_pp, {H{1'b0}}};
            HH:      w_term = {w_pp, {W{1'b0}}};
            default: ;
        endcase
    end

    assign w_acc_fin = r_acc + w_term;

    // Truncating the magnitude rounds toward zero; -0 cannot appear since -0 == 0.
    assign w_mag    = w_acc_fin[FRAC +: W];
    assign w_ovf    = (|w_acc_fin[2*W-1:W+FRAC]) ||
                      (r_neg ? (w_mag > QMIN) : (w_mag > QMAX));
    assign w_signed = r_neg ? -$signed(w_mag) : $signed(w_mag);

`ifdef FXP_MUL_SAT_EN
    function automatic logic [W-1:0] f_sat(input logic signed [W-1:0] v,
                                            input logic neg,
                                            input logic of);
        if (of)
            return neg ? QMIN : QMAX;
        return v;
    endfunction

    assign w_res = f_sat(w_signed, r_neg, w_ovf);
`else
    assign w_res = w_signed;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mag_a    <= mag32(A);
                        r_mag_b    <= mag32(B);
                        r_neg      <= A[W-1] ^ B[W-1];
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= LL;
                    end
                end
                LL: begin
                    r_acc   <= w_acc_fin;
                    r_state <= LH;
                end
                LH: begin
                    r_acc   <= w_acc_fin;
                    r_state <= HL;
                end
                HL: begin
                    r_acc   <= w_acc_fin;
                    r_state <= HH;
                end
                HH: begin
                    r_acc       <= w_acc_fin;
                    r_result    <= w_res;
                    r_ovf       <= w_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    // Returning to IDLE first keeps consume and accept on separate edges.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_fxp_mul_seq.sv
// Directed self-checking bench for fxp_mul_seq (both saturation builds).
module tb_fxp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        ovf;

    int n_assert = 0;
    int n_fail   = 0;

    fxp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one pair, check latency, result and ovf, then consume.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_o, input bit hold);
        logic [31:0] r0;
        logic        o0;
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        A = a;
        B = b;
        tick();
        in_valid = 1'b0;
        A = 32'hDEAD_BEEF;
        B = 32'h1234_5678;
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        tick();
        check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, result, exp_r);
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_o});
        if (hold) begin
            r0 = result;
            o0 = ovf;
            for (int i = 0; i < 3; i++) begin
                tick();
                check({tag, "_hold_res"}, result, exp_r);
                check({tag, "_hold_ovf"}, {31'd0, ovf}, {31'd0, o0});
                check({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
                check({tag, "_hold_vld"}, {31'd0, out_valid}, 32'd1);
            end
            check({tag, "_hold_r0"}, r0, exp_r);
            // Offer a new pair on the consume edge; it must not be taken.
            in_valid = 1'b1;
            A = 32'h0001_0000;
            B = 32'h0001_0000;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_cons_vld"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_cons_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [31:0] exp_big_pos;
    logic [31:0] exp_big_neg;
    logic [31:0] exp_edge_pos;

    initial begin
`ifdef FXP_MUL_SAT_EN
        exp_big_pos  = 32'h7FFF_FFFF;
        exp_big_neg  = 32'h8000_0000;
        exp_edge_pos = 32'h7FFF_FFFF;
`else
        exp_big_pos  = 32'h0000_0000;
        exp_big_neg  = 32'h0000_0000;
        exp_edge_pos = 32'h8000_0000;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        tick();
        tick();
        check("rst_rdy", {31'd0, in_ready}, 32'd1);
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        check("rst_res", result, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("p1p5x3p25", 32'h0001_8000, 32'h0003_4000, 32'h0004_E000, 1'b0, 1'b0);
        run_op("n1p5x3p25", 32'hFFFE_8000, 32'h0003_4000, 32'hFFFB_2000, 1'b0, 1'b0);
        run_op("nxn",       32'hFFFE_8000, 32'hFFFC_C000, 32'h0004_E000, 1'b0, 1'b0);
        run_op("big_pos",   32'h0100_0000, 32'h0100_0000, exp_big_pos,   1'b1, 1'b0);
        run_op("big_neg",   32'h0100_0000, 32'hFF00_0000, exp_big_neg,   1'b1, 1'b0);
        run_op("edge_pos",  32'h0080_0000, 32'h0100_0000, exp_edge_pos,  1'b1, 1'b0);
        run_op("edge_neg",  32'h0080_0000, 32'hFF00_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op("min_x1",    32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op("lsb_x_lsb", 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        run_op("neg_tiny",  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        run_op("zero",      32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op("hold",      32'h0002_0000, 32'h0003_0000, 32'h0006_0000, 1'b0, 1'b1);

        // Reset mid-operation while in LH.
        in_valid = 1'b1;
        A = 32'h0100_0000;
        B = 32'h0100_0000;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        check("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        check("mid_rst_res", result, 32'd0);
        check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("mid_rst_idle", {31'd0, out_valid}, 32'd0);
        run_op("after_rst", 32'h0001_8000, 32'h0003_4000, 32'h0004_E000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
